// File: rtl/pdp8_fetch_decode.sv
// rtl/pdp8_fetch_decode.sv - PDP-8 instruction fetch/decode stage
//
// Fetches one instruction word at a time, resolves its effective address
// (zero page / current page, indirect, optional auto-index) and presents
// the decoded instruction for exactly one cycle. It then waits for the
// execution unit to release stall and supply the next PC.
//
// Optional feature macro: PDP8_AUTOINDEX_EN
//   defined   - indirect references through 0010-0017 pre-increment the
//               pointer and write it back in a dedicated AUTO_WR cycle.
//   undefined - those locations are ordinary pointers; write port tied to 0.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   ifu_rd_req_o/addr_o memory read request/address (data one cycle later)
//   ifu_rd_data_i       memory read data
//   ifu_wr_req_o/addr_o/data_o  auto-index write-back
//   stall_i, PC_value_i execution handshake and next PC
//   base_addr_o         effective address of the issued MRI
//   pdp_mem_opcode_o    one-hot MRI opcode plus operand address
//   pdp_op7_opcode_o    decoded group-1/group-2 microinstruction bits

package pdp8_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef struct packed {
    logic                  and_op;
    logic                  tad;
    logic                  isz;
    logic                  dca;
    logic                  jms;
    logic                  jmp;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic cla1;
    logic cll;
    logic cma;
    logic cml;
    logic rar;
    logic ral;
    logic rtr;
    logic rtl;
    logic bsw;
    logic iac;
    logic cla2;
    logic sma;
    logic sza;
    logic snl;
    logic spa;
    logic sna;
    logic szl;
    logic skp;
    logic osr;
    logic hlt;
  } pdp_op7_opcode_s;
endpackage

module pdp8_fetch_decode
  import pdp8_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic                  ifu_rd_req_o,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data_i,
  output logic                  ifu_wr_req_o,
  output logic [ADDR_WIDTH-1:0] ifu_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ifu_wr_data_o,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH-1:0] PC_value_i,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output pdp_mem_opcode_s       pdp_mem_opcode_o,
  output pdp_op7_opcode_s       pdp_op7_opcode_o
);

`ifdef PDP8_AUTOINDEX_EN
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IND_RD, S_IND_DATA, S_AUTO_WR, S_ISSUE, S_WAIT_EXEC
  } state_e;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IND_RD, S_IND_DATA, S_ISSUE, S_WAIT_EXEC
  } state_e;
`endif

  // Page bit selects current page (from the fetch PC) or page zero.
  function automatic logic [ADDR_WIDTH-1:0] direct_addr(input logic [4:0] page,
                                                         input logic [7:0] pofs);
    return pofs[7] ? {page, pofs[6:0]} : {5'b0, pofs[6:0]};
  endfunction

  function automatic pdp_mem_opcode_s mri_decode(input logic [2:0] op,
                                                 input logic [ADDR_WIDTH-1:0] ea);
    pdp_mem_opcode_s m;
    m = '0;
    m.mem_inst_addr = ea;
    case (op)
      3'd0:    m.and_op = 1'b1;
      3'd1:    m.tad    = 1'b1;
      3'd2:    m.isz    = 1'b1;
      3'd3:    m.dca    = 1'b1;
      3'd4:    m.jms    = 1'b1;
      3'd5:    m.jmp    = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // w is instruction bits [8:0]; bit 8 picks group 2, bit 0 in group 2
  // marks group 3 (EAE), which this stage leaves undecoded.
  function automatic pdp_op7_opcode_s op7_decode(input logic [8:0] w);
    pdp_op7_opcode_s o;
    logic g1, g2;
    g1 = ~w[8];
    g2 = w[8] & ~w[0];
    o = '0;
    o.nop  = g1 & (w[7:0] == 8'd0);
    o.cla1 = g1 & w[7];
    o.cll  = g1 & w[6];
    o.cma  = g1 & w[5];
    o.cml  = g1 & w[4];
    // Bit 1 doubles a rotate; with no rotate selected it is a byte swap.
    o.rar  = g1 & w[3] & ~w[1];
    o.ral  = g1 & w[2] & ~w[1];
    o.rtr  = g1 & w[3] & w[1];
    o.rtl  = g1 & w[2] & w[1];
    o.bsw  = g1 & w[1] & ~w[3] & ~w[2];
    o.iac  = g1 & w[0];
    // Bit 3 reverses the skip sense; with no condition it is an unconditional skip.
    o.cla2 = g2 & w[7];
    o.sma  = g2 & ~w[3] & w[6];
    o.sza  = g2 & ~w[3] & w[5];
    o.snl  = g2 & ~w[3] & w[4];
    o.spa  = g2 & w[3] & w[6];
    o.sna  = g2 & w[3] & w[5];
    o.szl  = g2 & w[3] & w[4];
    o.skp  = g2 & w[3] & (w[6:4] == 3'd0);
    o.osr  = g2 & w[2];
    o.hlt  = g2 & w[1];
    return o;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]            opc_q, opc_d;
  logic                  wait_first_q, wait_first_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  pdp_mem_opcode_s       mem_q, mem_d;
  pdp_op7_opcode_s       op7_q, op7_d;
`ifdef PDP8_AUTOINDEX_EN
  logic [ADDR_WIDTH-1:0] dir_q, dir_d;
  logic [ADDR_WIDTH-1:0] eff_q, eff_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
`endif

  logic [2:0]            fetch_opc;
  logic [ADDR_WIDTH-1:0] fetch_dir;

  assign fetch_opc = ifu_rd_data_i[11:9];
  assign fetch_dir = direct_addr(pc_q[11:7], ifu_rd_data_i[7:0]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opc_d        = opc_q;
    wait_first_d = wait_first_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = '0;
    base_d       = '0;
    mem_d        = '0;
    op7_d        = '0;
`ifdef PDP8_AUTOINDEX_EN
    dir_d        = dir_q;
    eff_d        = eff_q;
    wr_req_d     = 1'b0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
`endif
    case (state_q)
      // Outputs are registered, so every transition into FETCH launches the
      // read itself. Only the FETCH that follows reset arrives with no read
      // in flight; it spends one cycle launching it.
      S_FETCH: begin
        if (!rd_req_q) begin
          rd_req_d  = 1'b1;
          rd_addr_d = pc_q;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opc_d = fetch_opc;
`ifdef PDP8_AUTOINDEX_EN
        dir_d = fetch_dir;
`endif
        if (fetch_opc == 3'd6) begin
          // IOT: no peripherals here, skip straight to the next word.
          pc_d      = pc_q + 1'b1;
          state_d   = S_FETCH;
          rd_req_d  = 1'b1;
          rd_addr_d = pc_q + 1'b1;
        end else if (fetch_opc == 3'd7) begin
          state_d = S_ISSUE;
          op7_d   = op7_decode(ifu_rd_data_i[8:0]);
        end else if (ifu_rd_data_i[8]) begin
          state_d   = S_IND_RD;
          rd_req_d  = 1'b1;
          rd_addr_d = fetch_dir;
        end else begin
          state_d = S_ISSUE;
          base_d  = fetch_dir;
          mem_d   = mri_decode(fetch_opc, fetch_dir);
        end
      end
      S_IND_RD: state_d = S_IND_DATA;
      S_IND_DATA: begin
`ifdef PDP8_AUTOINDEX_EN
        if (dir_q[11:3] == 9'o001) begin
          eff_d     = ifu_rd_data_i + 1'b1;
          state_d   = S_AUTO_WR;
          wr_req_d  = 1'b1;
          wr_addr_d = dir_q;
          wr_data_d = ifu_rd_data_i + 1'b1;
        end else
`endif
        begin
          state_d = S_ISSUE;
          base_d  = ifu_rd_data_i;
          mem_d   = mri_decode(opc_q, ifu_rd_data_i);
        end
      end
`ifdef PDP8_AUTOINDEX_EN
      S_AUTO_WR: begin
        state_d = S_ISSUE;
        base_d  = eff_q;
        mem_d   = mri_decode(opc_q, eff_q);
      end
`endif
      S_ISSUE: begin
        state_d      = S_WAIT_EXEC;
        wait_first_d = 1'b1;
      end
      S_WAIT_EXEC: begin
        // Execution raises stall only after seeing the issue, so the first
        // cycle here is spent regardless of stall.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (!stall_i) begin
          pc_d      = PC_value_i;
          state_d   = S_FETCH;
          rd_req_d  = 1'b1;
          rd_addr_d = PC_value_i;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_FETCH;
      pc_q         <= START_ADDR;
      opc_q        <= '0;
      wait_first_q <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      base_q       <= '0;
      mem_q        <= '0;
      op7_q        <= '0;
`ifdef PDP8_AUTOINDEX_EN
      dir_q        <= '0;
      eff_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      opc_q        <= opc_d;
      wait_first_q <= wait_first_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      base_q       <= base_d;
      mem_q        <= mem_d;
      op7_q        <= op7_d;
`ifdef PDP8_AUTOINDEX_EN
      dir_q        <= dir_d;
      eff_q        <= eff_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
`endif
    end
  end

  assign ifu_rd_req_o     = rd_req_q;
  assign ifu_rd_addr_o    = rd_addr_q;
  assign base_addr_o      = base_q;
  assign pdp_mem_opcode_o = mem_q;
  assign pdp_op7_opcode_o = op7_q;
`ifdef PDP8_AUTOINDEX_EN
  assign ifu_wr_req_o     = wr_req_q;
  assign ifu_wr_addr_o    = wr_addr_q;
  assign ifu_wr_data_o    = wr_data_q;
`else
  assign ifu_wr_req_o     = 1'b0;
  assign ifu_wr_addr_o    = '0;
  assign ifu_wr_data_o    = '0;
`endif

endmodule

// File: doc/pdp8_fetch_decode.md
# pdp8_fetch_decode

Instruction fetch/decode stage of the PDP-8 core. It sits directly upstream of `instr_exec`. It fetches instruction words from memory and resolves the effective address, including page, indirect and optional auto-index handling. It presents one decoded instruction at a time on `base_addr`/`pdp_mem_opcode`/`pdp_op7_opcode`, then waits on the execution unit's `stall`/`PC_value` handshake before fetching the next word.

## Interface
- `START_ADDR`, default 12'o0200: PC value loaded at reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ifu_rd_req` in→out 1: memory read request; driven by this block.
- `ifu_rd_addr` out `ADDR_WIDTH`: read address, valid while `ifu_rd_req` is high.
- `ifu_rd_data` in `DATA_WIDTH`: read data, valid the cycle after the request.
- `ifu_wr_req` out 1: auto-index write-back request. Constant 0 unless `PDP8_AUTOINDEX_EN` is defined.
- `ifu_wr_addr` out `ADDR_WIDTH`: write address.
- `ifu_wr_data` out `DATA_WIDTH`: write data.
- `stall` in 1: driven by `instr_exec`; high while an instruction executes.
- `PC_value` in `ADDR_WIDTH`: next PC from `instr_exec`; valid when `stall` is low.
- `base_addr` out `ADDR_WIDTH`: effective address of the issued memory-reference instruction (MRI).
- `pdp_mem_opcode` out `pdp8_pkg::pdp_mem_opcode_s`: one-hot AND/TAD/ISZ/DCA/JMS/JMP plus the operand address.
- `pdp_op7_opcode` out `pdp8_pkg::pdp_op7_opcode_s`: group-1/group-2 microinstruction bits.

## Operation
- Instruction word fields: [11:9] opcode, [8] I (indirect), [7] P (current page), [6:0] offset.
- Direct address:
  - P=0 → {5'b0, offset}.
  - P=1 → {PC[11:7], offset}, where PC is the address the instruction was fetched from.
- State machine: FETCH → DECODE → (IND_RD → IND_DATA → [AUTO_WR]) → ISSUE → WAIT_EXEC → FETCH.
- FETCH: drive `ifu_rd_req`=1 with `ifu_rd_addr`=PC.
- DECODE: capture `ifu_rd_data` and route on opcode:
  - Opcodes 0–5 with I=0 → ISSUE using the direct address.
  - Opcodes 0–5 with I=1 → IND_RD. JMP with I=1 is also indirect.
  - Opcode 7 → ISSUE with no address.
  - Opcode 6 (IOT) is a NOP: set PC = PC+1 (mod 4096) and return to FETCH. Nothing is issued.
- IND_RD: read the pointer word at the direct address.
- IND_DATA:
  - Capture the pointer; the effective address is the pointer value.
  - If the direct address is in 12'o0010–12'o0017 and `PDP8_AUTOINDEX_EN` is defined: pointer+1 (mod 4096) becomes the effective address, and the FSM goes to AUTO_WR.
- AUTO_WR: one cycle with `ifu_wr_req`=1, `ifu_wr_addr` = direct address, `ifu_wr_data` = incremented pointer.
- ISSUE: exactly one cycle.
  - The matching one-hot field is set and `base_addr` = effective address. For opcode 7, the decoded `pdp_op7_opcode` bits are set instead.
  - In every other state, all opcode struct fields and `base_addr` are 0.
- WAIT_EXEC:
  - The first cycle is unconditional; `stall` is ignored.
  - After that, the first cycle with `stall`=0 loads PC ← `PC_value` and moves to FETCH.
- Read and write are never requested in the same cycle.

## Timing
- Reset values:
  - State FETCH, PC = `START_ADDR`.
  - All outputs 0, so the first read is requested in the cycle after reset is released.
- Memory read latency is 1 cycle; `ifu_rd_data` is sampled in the state after the request.
- Latency from fetch to issue (cycles, inclusive):
  - Direct: 3.
  - Indirect: 5.
  - Auto-index: 6.
- Minimum spacing between issues, with `stall` low immediately: direct instructions 5 cycles.
- `reset` in any state, including mid-indirect or AUTO_WR, aborts the operation next edge. No write is issued after `reset` is sampled high.
- A change on `PC_value` while `stall`=1 is ignored.
- The page calculation uses the fetch PC, not PC+1. So 12'o7777 with P=1 maps to page 12'o7600.

## Configuration
- `PDP8_AUTOINDEX_EN` defined:
  - Indirect references through 12'o0010–12'o0017 pre-increment the pointer.
  - The increment is written back via AUTO_WR.
- Not defined:
  - Those locations behave as ordinary indirect pointers.
  - `ifu_wr_req`/`ifu_wr_addr`/`ifu_wr_data` are tied to 0 and the AUTO_WR state does not exist.

## Test plan
- Direct current page, zero page, and issue timing:
  - Reset, mem[12'o0200]=12'o1205 (TAD, P=1) → `ifu_rd_addr`=12'o0200, TAD issued with `base_addr`=12'o0205 three cycles after the fetch request.
  - Repeat with mem[12'o0200]=12'o1005 (TAD, P=0) → `base_addr`=12'o0005.
- Indirect: mem[12'o0200]=12'o3420 (DCA I 0020), mem[12'o0020]=12'o4567 → DCA issued with `base_addr`=12'o4567 and no write.
- Auto-index wrap: mem[12'o0200]=12'o1410 (TAD I 0010), mem[12'o0010]=12'o7777.
  - `_EN` defined → write of 12'o0000 to 12'o0010, `base_addr`=12'o0000.
  - `_EN` undefined → `base_addr`=12'o7777, `ifu_wr_req` never high.
- Stall handshake: after issue, hold `stall`=1 for 4 cycles with `PC_value`=12'o0300 → next `ifu_rd_addr`=12'o0300 one cycle after `stall` falls. Glitches on `PC_value` during the stall have no effect.
- IOT and group 1: mem[12'o0200]=12'o6001, mem[12'o0201]=12'o7200 → no issue for the IOT, next fetch at 12'o0201, then CLA decoded in `pdp_op7_opcode`.
- Reset mid-indirect: assert `reset` during IND_DATA → all outputs 0 next cycle, then a fresh fetch at `START_ADDR`.
